// File: rtl/cpa_pipe_24.sv
// ---------------------------------------------------------------------------
// cpa_pipe_24
//
// Two-stage pipelined carry-propagate adder. Resolves the redundant sum/carry
// pair coming out of the 24-bit 3:2 CSA into a single binary result. The
// carry chain is split at a fixed boundary: stage 1 adds the low LO_W bits
// and registers the carry out, stage 2 adds the high part plus that carry.
//
// Parameters
//   W     width of the CSA sum vector (carry is W+1, result is W+2)
//   LO_W  number of low bits resolved in stage 1, 1 <= LO_W <= W
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   upstream sum/carry pair valid
//   in_ready   block can accept a pair this cycle
//   in_s       CSA sum vector   [W:1]
//   in_c       CSA carry vector [W+1:1], already shifted, bit 1 still added
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_sum    in_s + in_c, exact, [W+2:1]
// ---------------------------------------------------------------------------
module cpa_pipe_24 #(
  parameter int W    = 24,
  parameter int LO_W = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W:1]     in_s,
  input  logic [W+1:1]   in_c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W+2:1]   out_sum
);

  // Width of the high-part adder: the remaining sum bits, the carry MSB and
  // one extra bit so the final result can never overflow.
  localparam int HI_W = W + 2 - LO_W;

  // Stage-1 registers
  logic              s1_valid;
  logic [LO_W:1]     s1_lo;
  logic              s1_carry;
  logic [HI_W:1]     s1_s_hi;
  logic [HI_W:1]     s1_c_hi;

  // Handshake / datapath nets
  logic              s2_en;
  logic              s1_en;
  logic              accept;
  logic [LO_W+1:1]   lo_sum;
  logic [W:1]        s_shift;
  logic [W+1:1]      c_shift;
  logic [HI_W:1]     hi_sum;

  // -------------------------------------------------------------------------
  // Pipeline control. Stage 2 may load when its slot is empty or being
  // drained this cycle; stage 1 may load when empty or when it can move on.
  // in_ready is forced low during reset so no pair is claimed as accepted
  // on an edge that is about to discard it.
  // -------------------------------------------------------------------------
  always_comb begin
    s2_en    = !out_valid || out_ready;
    s1_en    = !s1_valid || s2_en;
    in_ready = s1_en && !rst;
    accept   = in_valid && in_ready;
  end

  // -------------------------------------------------------------------------
  // Stage-1 arithmetic. Shifting instead of slicing keeps the high part
  // well-defined even when LO_W == W (the sum contributes nothing above the
  // split). The casts below zero-extend or drop known-zero bits only.
  // -------------------------------------------------------------------------
  // NOTE: every output of this always_comb is assigned unconditionally on
  // every pass, so no latch can be inferred.
  always_comb begin
    lo_sum  = {1'b0, in_s[LO_W:1]} + {1'b0, in_c[LO_W:1]};
    s_shift = in_s >> LO_W;
    c_shift = in_c >> LO_W;
  end

  // Stage-2 arithmetic: the carry used here is the one registered alongside
  // these high operands, so it always belongs to the same pair, stall or not.
  always_comb begin
    hi_sum = s1_s_hi + s1_c_hi + {{(HI_W-1){1'b0}}, s1_carry};
  end

  // -------------------------------------------------------------------------
  // Valid bits and the output register. out_sum is reset so it reads 0
  // after reset; it only reloads when stage 2 advances with real data, so
  // it holds steady through a stall.
  // -------------------------------------------------------------------------
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      if (s2_en) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_sum <= {hi_sum, s1_lo};
        end
      end
      if (s1_en) begin
        s1_valid <= accept;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage-1 data registers.
  // NOTE: these carry no reset; s1_valid gates their use, so leaving them
  // unreset saves reset fan-out without any observable effect.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_lo    <= lo_sum[LO_W:1];
      s1_carry <= lo_sum[LO_W+1];
      s1_s_hi  <= HI_W'(s_shift);
      s1_c_hi  <= HI_W'(c_shift);
    end
  end

endmodule

// File: tb/tb_cpa_pipe_24.sv
// ---------------------------------------------------------------------------
// tb_cpa_pipe_24
//
// Self-checking bench for cpa_pipe_24. The reference model is an in-order
// queue of expected results (in_s + in_c), each tagged with the number of
// clock edges it has spent inside the block. The head is visible on the
// output once it has been inside for at least one edge past its capture;
// in_ready drops only when two results are held and the output is stalled.
// ---------------------------------------------------------------------------
module tb_cpa_pipe_24;

  localparam int W    = 24;
  localparam int LO_W = 13;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W:1]      in_s;
  logic [W+1:1]    in_c;
  logic            out_valid;
  logic            out_ready;
  logic [W+2:1]    out_sum;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: expected results in acceptance order and their age.
  logic [W+2:1] q_sum[$];
  int           q_age[$];

  cpa_pipe_24 #(.W(W), .LO_W(LO_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  always #5 clk = ~clk;

  function automatic logic e_out_valid();
    return (q_sum.size() > 0) && (q_age[0] >= 1);
  endfunction

  function automatic logic e_in_ready();
    return !rst && !((q_sum.size() == 2) && !out_ready);
  endfunction

  function automatic logic [W+2:1] e_out_sum();
    return (q_sum.size() > 0) ? q_sum[0] : '0;
  endfunction

  // Advance one clock: decide transfers from the model, then update it.
  task automatic tick();
    logic acc;
    logic outx;
    logic [W+2:1] s;
    acc  = in_valid && e_in_ready();
    outx = e_out_valid() && out_ready;
    s    = {2'b00, in_s} + {1'b0, in_c};
    @(posedge clk);
    if (rst) begin
      q_sum.delete();
      q_age.delete();
    end else begin
      if (outx) begin
        void'(q_sum.pop_front());
        void'(q_age.pop_front());
      end
      foreach (q_age[i]) q_age[i] = q_age[i] + 1;
      if (acc) begin
        q_sum.push_back(s);
        q_age.push_back(0);
      end
    end
    @(negedge clk);
  endtask

  // ------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_s = 24'h123456; in_c = 25'h0ABCDEF;
    @(posedge clk);
    @(negedge clk);
    repeat (3) begin
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      n_vec++;
      if (out_sum !== 26'h0) begin
        n_err++; $display("FAIL reset_out_sum: got %h want 0", out_sum);
      end
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) begin
      #1;
      n_vec++;
      if (in_ready !== e_in_ready()) begin
        n_err++; $display("FAIL post_reset_in_ready: got %b want %b", in_ready, e_in_ready());
      end
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid);
      end
      tick();
    end
  endtask

  // One pair with out_ready high; result must appear on the next cycle
  // after acceptance and match the literal expectation.
  task automatic test_pair(input string name, input logic [W:1] s,
                           input logic [W+1:1] c, input logic [W+2:1] exp_sum);
    out_ready = 1'b1; in_valid = 1'b1; in_s = s; in_c = c;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    tick();
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL %s early_out_valid: got %b want 0", name, out_valid);
    end
    tick();
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_sum !== exp_sum) begin
      n_err++;
      $display("FAIL %s result: got valid=%b sum=%h want valid=1 sum=%h",
               name, out_valid, out_sum, exp_sum);
    end
    n_vec++;
    if (out_sum !== e_out_sum()) begin
      n_err++; $display("FAIL %s model: got %h want %h", name, out_sum, e_out_sum());
    end
    tick();
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL %s duplicate: got valid=%b want 0", name, out_valid);
    end
  endtask

  // Pairs (i, 2i), i = 1..8, pushed back-to-back with random backpressure.
  task automatic test_backpressure();
    int i = 1;
    int k = 1;
    int cyc = 0;
    while (k <= 8 && cyc < 300) begin
      in_valid  = (i <= 8);
      in_s      = W'(i);
      in_c      = (W+1)'(2 * i);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      n_vec++;
      if (in_ready !== e_in_ready()) begin
        n_err++; $display("FAIL bp_in_ready: got %b want %b cyc=%0d", in_ready, e_in_ready(), cyc);
      end
      n_vec++;
      if (out_valid !== e_out_valid()) begin
        n_err++; $display("FAIL bp_out_valid: got %b want %b cyc=%0d", out_valid, e_out_valid(), cyc);
      end
      if (e_out_valid()) begin
        n_vec++;
        if (out_sum !== e_out_sum()) begin
          n_err++; $display("FAIL bp_out_sum: got %h want %h cyc=%0d", out_sum, e_out_sum(), cyc);
        end
        if (out_ready) begin
          n_vec++;
          if (out_sum !== (W+2)'(3 * k)) begin
            n_err++; $display("FAIL bp_order: got %h want %h", out_sum, (W+2)'(3 * k));
          end
          k++;
        end
      end
      if (in_valid && e_in_ready()) i++;
      tick();
      cyc++;
    end
    if (k <= 8) begin
      n_vec++; n_err++;
      $display("FAIL bp_timeout: got %0d results want 8", k - 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_s      = W'($urandom);
      in_c      = (W+1)'($urandom);
      if ($urandom_range(0, 7) == 0) in_c = '1;
      if ($urandom_range(0, 7) == 0) in_s = '1;
      out_ready = ($urandom_range(0, 9) < 6) || (cyc >= 390);
      if (cyc >= 390) in_valid = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== e_in_ready()) begin
        n_err++; $display("FAIL rnd_in_ready: got %b want %b cyc=%0d", in_ready, e_in_ready(), cyc);
      end
      n_vec++;
      if (out_valid !== e_out_valid()) begin
        n_err++; $display("FAIL rnd_out_valid: got %b want %b cyc=%0d", out_valid, e_out_valid(), cyc);
      end
      if (e_out_valid()) begin
        n_vec++;
        if (out_sum !== e_out_sum()) begin
          n_err++; $display("FAIL rnd_out_sum: got %h want %h cyc=%0d", out_sum, e_out_sum(), cyc);
        end
      end
      tick();
    end
    n_vec++;
    if (q_sum.size() != 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL rnd_drain: got %0d pending valid=%b want 0", q_sum.size(), out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; in_valid = 1'b1;
    in_s = 24'h000AAA; in_c = 25'h0000555;
    tick();
    in_s = 24'h0BBBBB; in_c = 25'h0111111;
    tick();
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || q_sum.size() != 2) begin
      n_err++;
      $display("FAIL mid_full: got in_ready=%b out_valid=%b want in_ready=0 out_valid=1",
               in_ready, out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_flush: got out_valid=%b want 0", out_valid);
    end
    in_valid = 1'b1; in_s = 24'h000007; in_c = 25'h0000008;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_sum !== 26'h000000F) begin
      n_err++;
      $display("FAIL mid_after: got valid=%b sum=%h want valid=1 sum=000000f", out_valid, out_sum);
    end
    tick();
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_stale: got out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_pair("basic",     24'h000005, 25'h0000006, 26'h000000B);
    test_pair("split",     24'h001FFF, 25'h0000002, 26'h0002001);
    test_pair("max",       24'hFFFFFF, 25'h1FFFFFE, 26'h2FFFFFD);
    test_pair("c_bit1",    24'h000000, 25'h0000001, 26'h0000001);
    test_backpressure();
    out_ready = 1'b1;
    repeat (3) tick();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
